seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. All digits share one BCD-to-7-segment decoder.
- Holds a double-buffered digit register and sequences one digit at a time onto the shared decoder's 4-bit BCD input.
- Drives active-low digit enables, with a blanking guard between digits to prevent ghosting.
- Optional leading-zero blanking; new display values are committed only at frame boundaries, so no tearing.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_lzb_mask.sv | 37 +++
 rtl/seg7_scan_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants and types for the 7-segment scan controller.
//            BCD_W     - width of one BCD digit
//            BCD_BLANK - code the shared decoder renders as all segments off
//            state_t   - scan FSM states
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int          BCD_W     = 4;
    localparam logic [3:0]  BCD_BLANK = 4'hF;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_lzb_mask.sv
`default_nettype none
// ============================================================================
// Module   : seg7_lzb_mask
// Purpose  : Leading-zero blanking mask. Digit k (k >= 1) is blanked when it
//            and every more significant digit are zero. Digit 0 is never
//            blanked so a zero value still shows a single "0". Non-BCD codes
//            (A..F) count as nonzero.
// Ports    : i_digits  - packed BCD digits, digit 0 in the low nibble
//            i_lzb_en  - blanking enable
//            o_blank   - per-digit blank flag
// Revision : 1.0 - initial release
// ============================================================================
module seg7_lzb_mask
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [BCD_W*NUM_DIGITS-1:0] i_digits,
    input  logic                        i_lzb_en,
    output logic [NUM_DIGITS-1:0]       o_blank
);

    logic w_zero_run;

    // Walk from the most significant digit down; the run of zeros stops at
    // the first nonzero digit.
    always_comb begin
        o_blank    = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run && (i_digits[k*BCD_W +: BCD_W] == '0);
            o_blank[k] = i_lzb_en && w_zero_run;
        end
    end

endmodule : seg7_lzb_mask
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : Time-multiplexed scan controller for an N-digit common-anode
//            7-segment display sharing one BCD decoder. Double-buffered digit
//            storage commits at frame boundaries; a blank gap separates
//            digits to avoid ghosting.
// Ports    : clk, rst_n       - clock, async active-low reset
//            en              - scan enable (low = dark)
//            load            - capture digits_in/dp_in into shadow
//            digits_in/dp_in - new display value
//            lzb_en          - leading-zero blanking enable
//            bcd_out         - BCD code to shared decoder (4'hF = blank)
//            an_n            - active-low digit enables
//            dp_out          - decimal point of the driven digit
//            pending         - shadow holds uncommitted data
//            frame_done      - one-cycle pulse per frame end / idle commit
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        lzb_en,
    output logic [BCD_W-1:0]            bcd_out,
    output logic [NUM_DIGITS-1:0]       an_n,
    output logic                        dp_out,
    output logic                        pending,
    output logic                        frame_done
);

    localparam int c_cnt_max = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam int c_idx_w   = $clog2(NUM_DIGITS);

    localparam logic [c_cnt_w-1:0] c_drive_tc = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_blank_tc = c_cnt_w'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_DIGITS - 1);
    localparam bit                 c_no_blank = (BLANK_CYCLES == 0);

    // Scan state
    state_t                      r_state;
    logic [c_idx_w-1:0]          r_idx;
    logic [c_cnt_w-1:0]          r_cnt;
    // Set while in the lead-in blank after reset or disable: its end starts
    // digit 0 instead of advancing the index.
    logic                        r_first;
    // en was low on the previous edge; an idle commit waits one cycle.
    logic                        r_idle;

    // Buffers
    logic [BCD_W*NUM_DIGITS-1:0] r_sh_dig;
    logic [NUM_DIGITS-1:0]       r_sh_dp;
    logic [BCD_W*NUM_DIGITS-1:0] r_act_dig;
    logic [NUM_DIGITS-1:0]       r_act_dp;
    logic                        r_pending;

    // Registered outputs
    logic [NUM_DIGITS-1:0]       r_an_n;
    logic [BCD_W-1:0]            r_bcd;
    logic                        r_dp;
    logic                        r_frame_done;

    // Next-state wires
    state_t                      w_state_nxt;
    logic [c_idx_w-1:0]          w_idx_nxt;
    logic [c_cnt_w-1:0]          w_cnt_nxt;
    logic                        w_first_nxt;
    logic                        w_slot_end;
    logic                        w_frame_end;
    logic                        w_idle_commit;
    logic                        w_commit;
    logic [BCD_W*NUM_DIGITS-1:0] w_sh_dig_nxt;
    logic [NUM_DIGITS-1:0]       w_sh_dp_nxt;
    logic [BCD_W*NUM_DIGITS-1:0] w_act_dig_nxt;
    logic [NUM_DIGITS-1:0]       w_act_dp_nxt;
    logic                        w_pending_nxt;
    logic                        w_frame_done_nxt;
    logic [NUM_DIGITS-1:0]       w_blank_mask;
    logic [NUM_DIGITS-1:0]       w_an_n_nxt;
    logic [BCD_W-1:0]            w_bcd_nxt;
    logic                        w_dp_nxt;

    // ------------------------------------------------------------------
    // Next-state logic: scan sequencing, commit and buffer updates
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_first_nxt   = r_first;
        w_slot_end    = 1'b0;
        w_frame_end   = 1'b0;
        w_idle_commit = 1'b0;

        if (!en) begin
            w_state_nxt   = ST_BLANK;
            w_idx_nxt     = '0;
            w_cnt_nxt     = '0;
            w_first_nxt   = 1'b1;
            w_idle_commit = r_idle && r_pending;
        end else begin
            case (r_state)
                ST_DRIVE: begin
                    if (r_cnt == c_drive_tc) begin
                        w_cnt_nxt = '0;
                        if (c_no_blank) begin
                            w_slot_end = 1'b1;
                        end else begin
                            w_state_nxt = ST_BLANK;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (c_no_blank || (r_cnt == c_blank_tc)) begin
                        w_cnt_nxt  = '0;
                        w_slot_end = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            endcase

            if (w_slot_end) begin
                w_state_nxt = ST_DRIVE;
                w_first_nxt = 1'b0;
                if (r_first) begin
                    w_idx_nxt = '0;
                end else if (r_idx == c_last_idx) begin
                    w_idx_nxt   = '0;
                    w_frame_end = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
        end

        w_commit         = (w_frame_end || w_idle_commit) && r_pending;
        w_frame_done_nxt = w_frame_end || w_idle_commit;

        // Commit reads the old shadow, so a coincident load stays pending.
        w_act_dig_nxt = w_commit ? r_sh_dig : r_act_dig;
        w_act_dp_nxt  = w_commit ? r_sh_dp  : r_act_dp;
        w_sh_dig_nxt  = load ? digits_in : r_sh_dig;
        w_sh_dp_nxt   = load ? dp_in     : r_sh_dp;
        if (load) begin
            w_pending_nxt = 1'b1;
        end else if (w_commit) begin
            w_pending_nxt = 1'b0;
        end else begin
            w_pending_nxt = r_pending;
        end
    end

    // Mask is evaluated on the post-commit value so the first digit of a
    // new frame already shows the new data correctly blanked.
    seg7_lzb_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lzb_mask (
        .i_digits   (w_act_dig_nxt),
        .i_lzb_en   (lzb_en),
        .o_blank    (w_blank_mask)
    );

    // Outputs are registered from the next state so they line up exactly
    // with the state they describe.
    always_comb begin
        w_an_n_nxt = '1;
        w_bcd_nxt  = BCD_BLANK;
        w_dp_nxt   = 1'b0;
        if (w_state_nxt == ST_DRIVE) begin
            w_an_n_nxt[w_idx_nxt] = 1'b0;
            w_bcd_nxt = w_blank_mask[w_idx_nxt] ? BCD_BLANK
                                                : w_act_dig_nxt[w_idx_nxt*BCD_W +: BCD_W];
            w_dp_nxt  = w_act_dp_nxt[w_idx_nxt];
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BLANK;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_first      <= 1'b1;
            r_idle       <= 1'b0;
            r_sh_dig     <= '0;
            r_sh_dp      <= '0;
            r_act_dig    <= '0;
            r_act_dp     <= '0;
            r_pending    <= 1'b0;
            r_an_n       <= '1;
            r_bcd        <= BCD_BLANK;
            r_dp         <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_first      <= w_first_nxt;
            r_idle       <= !en;
            r_sh_dig     <= w_sh_dig_nxt;
            r_sh_dp      <= w_sh_dp_nxt;
            r_act_dig    <= w_act_dig_nxt;
            r_act_dp     <= w_act_dp_nxt;
            r_pending    <= w_pending_nxt;
            r_an_n       <= w_an_n_nxt;
            r_bcd        <= w_bcd_nxt;
            r_dp         <= w_dp_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign an_n       = r_an_n;
    assign bcd_out    = r_bcd;
    assign dp_out     = r_dp;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule : seg7_scan_ctrl
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Purpose  : Self-checking bench for seg7_scan_ctrl (4 digits, 4-cycle drive,
//            1-cycle blank). A reference model tracks the display as a
//            position in a global frame timeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 1;
    localparam int F = N * (R + B);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lzb_en = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  an_n;
    logic        dp_out;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .lzb_en     (lzb_en),
        .bcd_out    (bcd_out),
        .an_n       (an_n),
        .dp_out     (dp_out),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_s counts enabled edges since reset / re-enable; display cycle
    // c = m_s - B (negative = lead-in blank).
    int          m_s;
    logic [15:0] m_sh, m_act;
    logic [3:0]  m_sdp, m_adp;
    logic        m_pend, m_fd, m_idle, m_lzb;
    bit          fe, ic, cm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s <= 0; m_sh <= '0; m_act <= '0; m_sdp <= '0; m_adp <= '0;
            m_pend <= 1'b0; m_fd <= 1'b0; m_idle <= 1'b0; m_lzb <= 1'b0;
        end else begin
            fe = 1'b0;
            ic = 1'b0;
            if (!en) begin
                ic  = m_idle && m_pend;
                m_s <= 0;
            end else begin
                fe  = (m_s + 1 - B > 0) && ((m_s + 1 - B) % F == 0);
                m_s <= m_s + 1;
            end
            m_idle <= !en;
            m_lzb  <= lzb_en;
            cm = (fe || ic) && m_pend;
            if (cm) begin
                m_act <= m_sh;
                m_adp <= m_sdp;
            end
            if (load) begin
                m_sh  <= digits_in;
                m_sdp <= dp_in;
            end
            m_pend <= load ? 1'b1 : (cm ? 1'b0 : m_pend);
            m_fd   <= fe || ic;
        end
    end

    // Expected {an_n, bcd_out, dp_out, pending, frame_done}
    function automatic logic [10:0] exp_vec();
        int          c, pos, d;
        logic [3:0]  an;
        logic [3:0]  b;
        logic [15:0] t;
        logic        dpv;
        an = 4'hF; b = 4'hF; dpv = 1'b0;
        c = m_s - B;
        if (c >= 0) begin
            pos = c % F;
            d   = pos / (R + B);
            if (pos % (R + B) < R) begin
                an[d] = 1'b0;
                t     = m_act >> (4 * d);
                b     = t[3:0];
                if (m_lzb && d >= 1 && t == 16'h0) b = 4'hF;
                dpv = m_adp[d];
            end
        end
        return {an, b, dpv, m_pend, m_fd};
    endfunction

    function automatic bit next_is_fe();
        return en && (m_s + 1 - B > 0) && ((m_s + 1 - B) % F == 0);
    endfunction

    function automatic int drive_digit(input logic [3:0] a);
        for (int i = 0; i < N; i++) if (a == ~(4'b0001 << i)) return i;
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({an_n, bcd_out, dp_out, pending, frame_done} !== 11'b1111_1111_000) begin
            errors++;
            $display("FAIL reset_values got %b exp %b", {an_n, bcd_out, dp_out, pending, frame_done}, 11'b1111_1111_000);
        end
        en = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({an_n, bcd_out} !== 8'b1110_0000 || {an_n, bcd_out, dp_out, pending, frame_done} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_first_drive got %b exp %b", {an_n, bcd_out, dp_out, pending, frame_done}, exp_vec());
        end
    endtask

    task automatic test_basic();
        int seen[N];
        int nfd = 0, last_fd = 0, d;
        logic [15:0] exp_d;
        for (int i = 0; i < N; i++) seen[i] = -1;
        digits_in = 16'h1234; dp_in = 4'b0000; lzb_en = 1'b0; load = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            @(negedge clk);
            load = 1'b0;
            checks++;
            if ({an_n, bcd_out, dp_out, pending, frame_done} !== exp_vec()) begin
                errors++;
                $display("FAIL basic_cycle t=%0t got %b exp %b", $time, {an_n, bcd_out, dp_out, pending, frame_done}, exp_vec());
            end
            if (frame_done) begin
                if (nfd > 0) begin
                    checks++;
                    if (cyc - last_fd != F) begin
                        errors++;
                        $display("FAIL frame_period got %0d exp %0d", cyc - last_fd, F);
                    end
                end
                nfd++;
                last_fd = cyc;
            end
            d = drive_digit(an_n);
            if (nfd > 0 && d >= 0) seen[d] = int'(bcd_out);
        end
        exp_d = 16'h1234;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (seen[i] != int'((exp_d >> (4 * i)) & 16'hF)) begin
                errors++;
                $display("FAIL basic_digit%0d got %0d exp %0d", i, seen[i], (exp_d >> (4 * i)) & 16'hF);
            end
        end
    endtask

    task automatic test_lzb();
        logic [15:0] vals [3] = '{16'h0042, 16'h0042, 16'h0000};
        logic        lz   [3] = '{1'b1, 1'b0, 1'b1};
        logic [15:0] expb [3] = '{16'hFF42, 16'h0042, 16'hFFF0};
        int seen[N];
        int waited, d;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) seen[i] = -1;
            @(negedge clk);
            lzb_en = lz[k]; digits_in = vals[k]; load = 1'b1;
            waited = 0;
            do begin
                @(negedge clk);
                load = 1'b0;
                waited++;
                checks++;
                if ({an_n, bcd_out, dp_out, pending, frame_done} !== exp_vec()) begin
                    errors++;
                    $display("FAIL lzb_wait t=%0t got %b exp %b", $time, {an_n, bcd_out, dp_out, pending, frame_done}, exp_vec());
                end
            end while (!frame_done && waited < 2 * F);
            if (!frame_done) begin
                checks++; errors++;
                $display("FAIL lzb_timeout got no frame_done exp pulse within %0d", 2 * F);
            end
            for (int c = 0; c < F; c++) begin
                if (c > 0) @(negedge clk);
                d = drive_digit(an_n);
                if (d >= 0) seen[d] = int'(bcd_out);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (seen[i] != int'((expb[k] >> (4 * i)) & 16'hF)) begin
                    errors++;
                    $display("FAIL lzb_case%0d_digit%0d got %0h exp %0h", k, i, seen[i], (expb[k] >> (4 * i)) & 16'hF);
                end
            end
        end
    endtask

    task automatic test_midframe();
        int waited = 0;
        lzb_en = 1'b0;
        while (!((m_s - B >= 0) && ((m_s - B) % F == 7)) && waited < 2 * F) begin
            @(negedge clk);
            waited++;
        end
        digits_in = 16'h5678; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pending got %b exp 1", pending);
        end
        waited = 0;
        while (!frame_done && waited < 2 * F) begin
            checks++;
            if ({an_n, bcd_out, dp_out, pending, frame_done} !== exp_vec()) begin
                errors++;
                $display("FAIL midframe_hold t=%0t got %b exp %b", $time, {an_n, bcd_out, dp_out, pending, frame_done}, exp_vec());
            end
            @(negedge clk);
            waited++;
        end
        checks++;
        if ({frame_done, pending, an_n, bcd_out} !== {1'b1, 1'b0, 4'b1110, 4'h8}) begin
            errors++;
            $display("FAIL midframe_commit got %b exp %b", {frame_done, pending, an_n, bcd_out}, {1'b1, 1'b0, 4'b1110, 4'h8});
        end
    endtask

    task automatic test_back_to_back();
        int waited = 0;
        @(negedge clk);
        digits_in = 16'h1111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        while (!next_is_fe() && waited < 2 * F) begin
            @(negedge clk);
            waited++;
        end
        digits_in = 16'h9999; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if ({frame_done, pending, bcd_out} !== {1'b1, 1'b1, 4'h1} || {an_n, bcd_out, dp_out, pending, frame_done} !== exp_vec()) begin
            errors++;
            $display("FAIL b2b_commit got %b exp %b", {frame_done, pending, bcd_out}, {1'b1, 1'b1, 4'h1});
        end
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!frame_done && waited < 2 * F);
        checks++;
        if ({frame_done, pending, bcd_out} !== {1'b1, 1'b0, 4'h9}) begin
            errors++;
            $display("FAIL b2b_second got %b exp %b", {frame_done, pending, bcd_out}, {1'b1, 1'b0, 4'h9});
        end
    endtask

    task automatic test_async_reset();
        int waited = 0;
        while (an_n !== 4'b1011 && waited < 2 * F) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (an_n !== 4'b1011) begin
            errors++;
            $display("FAIL areset_reach_digit2 got %b exp 1011", an_n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({an_n, bcd_out, dp_out, pending, frame_done} !== 11'b1111_1111_000) begin
            errors++;
            $display("FAIL areset_immediate got %b exp %b", {an_n, bcd_out, dp_out, pending, frame_done}, 11'b1111_1111_000);
        end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        @(negedge clk);
        checks++;
        if ({an_n, bcd_out} !== 8'b1110_0000 || {an_n, bcd_out, dp_out, pending, frame_done} !== exp_vec()) begin
            errors++;
            $display("FAIL areset_restart got %b exp %b", {an_n, bcd_out}, 8'b1110_0000);
        end
    endtask

    task automatic test_en_off();
        repeat (6) @(negedge clk);
        digits_in = 16'h4321; dp_in = 4'b0101; load = 1'b1;
        @(negedge clk);
        load = 1'b0; en = 1'b0;
        @(negedge clk);
        checks++;
        if ({an_n, bcd_out, pending, frame_done} !== {4'hF, 4'hF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL enoff_dark got %b exp %b", {an_n, bcd_out, pending, frame_done}, {4'hF, 4'hF, 1'b1, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({an_n, pending, frame_done} !== {4'hF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL enoff_commit got %b exp %b", {an_n, pending, frame_done}, {4'hF, 1'b0, 1'b1});
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if ({an_n, bcd_out, dp_out, frame_done} !== {4'b1110, 4'h1, 1'b1, 1'b0} || {an_n, bcd_out, dp_out, pending, frame_done} !== exp_vec()) begin
            errors++;
            $display("FAIL enoff_resume got %b exp %b", {an_n, bcd_out, dp_out, frame_done}, {4'b1110, 4'h1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            checks++;
            if ({an_n, bcd_out, dp_out, pending, frame_done} !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle t=%0t got %b exp %b", $time, {an_n, bcd_out, dp_out, pending, frame_done}, exp_vec());
            end
            for (int i = 0; i < N; i++) v[4*i +: 4] = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom);
            digits_in = v;
            dp_in     = 4'($urandom);
            load      = ($urandom_range(7) == 0);
            if ($urandom_range(9) == 0) lzb_en = ~lzb_en;
            if (en) en = ($urandom_range(39) != 0);
            else    en = ($urandom_range(2) == 0);
        end
        load = 1'b0; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lzb();
        test_midframe();
        test_back_to_back();
        test_async_reset();
        test_en_off();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seg7_scan_ctrl
`default_nettype wire
